// File: rtl/conv_encoder.sv
// Rate-1/2, K=3 convolutional encoder (G = 111, 101) with a single-entry registered output slot.
// Define ENC_TAIL_EN to append two zero tail symbols per frame; otherwise the last bit closes the frame.
module conv_encoder #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 data_i,
    input  logic                 valid_i,
    input  logic                 last_i,
    output logic                 ready_o,
    output logic [1:0]           sym_o,
    output logic                 sym_valid_o,
    output logic                 sym_last_o,
    input  logic                 sym_ready_i,
    output logic [CNT_WIDTH-1:0] sym_cnt_o,
    output logic                 frame_done_o,
    output logic                 busy_o
);

`ifdef ENC_TAIL_EN
    typedef enum logic [1:0] {IDLE, ENC, TAIL1, TAIL2} state_t;
`else
    typedef enum logic [0:0] {IDLE, ENC} state_t;
`endif

    state_t     state, state_n;
    logic [1:0] enc_s;
    logic       slot_free;
    logic       accept;
    logic       load;
    logic       load_last;
    logic       clr_cnt;
    logic       zero_s;
    logic       enc_bit;

    // enc_s[1] is the oldest bit; the encoding register is {enc_s, b}.
    function automatic logic [1:0] enc_sym(input logic [1:0] s, input logic b);
        return {b ^ s[0] ^ s[1], b ^ s[1]};
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign slot_free    = !sym_valid_o || sym_ready_i;
    assign ready_o      = slot_free && (state == IDLE || state == ENC);
    assign accept       = valid_i && ready_o;
    assign busy_o       = (state != IDLE);
    assign frame_done_o = rst_ni && sym_valid_o && sym_ready_i && sym_last_o;

    always_comb begin
        state_n   = state;
        load      = 1'b0;
        load_last = 1'b0;
        clr_cnt   = 1'b0;
        zero_s    = 1'b0;
        enc_bit   = data_i;
        case (state)
            IDLE, ENC: begin
                if (accept) begin
                    load    = 1'b1;
                    clr_cnt = (state == IDLE);
                    if (last_i) begin
`ifdef ENC_TAIL_EN
                        state_n = TAIL1;
`else
                        load_last = 1'b1;
                        zero_s    = 1'b1;
                        state_n   = IDLE;
`endif
                    end else begin
                        state_n = ENC;
                    end
                end
            end
`ifdef ENC_TAIL_EN
            TAIL1: begin
                if (slot_free) begin
                    load    = 1'b1;
                    enc_bit = 1'b0;
                    state_n = TAIL2;
                end
            end
            TAIL2: begin
                if (slot_free) begin
                    load      = 1'b1;
                    enc_bit   = 1'b0;
                    load_last = 1'b1;
                    state_n   = IDLE;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    // Output slot stage: a load may coincide with a drain for full throughput.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= IDLE;
            enc_s       <= 2'b00;
            sym_o       <= 2'b00;
            sym_valid_o <= 1'b0;
            sym_last_o  <= 1'b0;
            sym_cnt_o   <= '0;
        end else begin
            state <= state_n;
            if (load) begin
                sym_o       <= enc_sym(enc_s, enc_bit);
                sym_last_o  <= load_last;
                sym_valid_o <= 1'b1;
                enc_s       <= zero_s ? 2'b00 : {enc_s[0], enc_bit};
                sym_cnt_o   <= clr_cnt ? CNT_WIDTH'(1) : sat_inc(sym_cnt_o);
            end else if (sym_ready_i) begin
                sym_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder: directed scenarios plus randomized frames against a convolution model.
// Follows the ENC_TAIL_EN build setting of the design.
module tb_conv_encoder;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          data = 1'b0;
    logic          valid = 1'b0;
    logic          last = 1'b0;
    logic          ready;
    logic [1:0]    sym;
    logic          sym_valid;
    logic          sym_last;
    logic          sym_ready = 1'b1;
    logic [CW-1:0] sym_cnt;
    logic          frame_done;
    logic          busy;

    typedef struct {
        logic [1:0] sym;
        logic       last;
        int         cnt;
    } sym_t;

    sym_t exp_q[$];
    sym_t got_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   done_seen = 0;
    int   done_exp = 0;
    bit   rand_bp = 0;
    bit   rand_gap = 0;

    conv_encoder #(.CNT_WIDTH(CW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .data_i      (data),
        .valid_i     (valid),
        .last_i      (last),
        .ready_o     (ready),
        .sym_o       (sym),
        .sym_valid_o (sym_valid),
        .sym_last_o  (sym_last),
        .sym_ready_i (sym_ready),
        .sym_cnt_o   (sym_cnt),
        .frame_done_o(frame_done),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    // Output monitor: records every symbol handshake and every frame_done pulse.
    always @(negedge clk) begin
        sym_t s;
        if (rst_n && sym_valid && sym_ready) begin
            s.sym  = sym;
            s.last = sym_last;
            s.cnt  = int'(sym_cnt);
            got_q.push_back(s);
        end
        if (frame_done) done_seen++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: X_k = u_k ^ u_{k-1} ^ u_{k-2}, Y_k = u_k ^ u_{k-2}, history zero at frame start.
    function automatic void model_frame(input bit bits[$]);
        bit   u[$];
        bit   m1, m2;
        sym_t e;
        u = bits;
`ifdef ENC_TAIL_EN
        u.push_back(1'b0);
        u.push_back(1'b0);
`endif
        for (int k = 0; k < u.size(); k++) begin
            m1     = (k >= 1) ? u[k-1] : 1'b0;
            m2     = (k >= 2) ? u[k-2] : 1'b0;
            e.sym  = {u[k] ^ m1 ^ m2, u[k] ^ m2};
            e.last = (k == u.size() - 1);
            e.cnt  = (k + 1 > CMAX) ? CMAX : k + 1;
            exp_q.push_back(e);
        end
        done_exp++;
    endfunction

    task automatic push_exp(input logic [1:0] s, input logic l, input int c);
        sym_t e;
        e.sym  = s;
        e.last = l;
        e.cnt  = c;
        exp_q.push_back(e);
    endtask

    task automatic expect_1011();
`ifdef ENC_TAIL_EN
        push_exp(2'b11, 1'b0, 1);
        push_exp(2'b10, 1'b0, 2);
        push_exp(2'b00, 1'b0, 3);
        push_exp(2'b01, 1'b0, 4);
        push_exp(2'b01, 1'b0, 5);
        push_exp(2'b11, 1'b1, 6);
`else
        push_exp(2'b11, 1'b0, 1);
        push_exp(2'b10, 1'b0, 2);
        push_exp(2'b00, 1'b0, 3);
        push_exp(2'b01, 1'b1, 4);
`endif
        done_exp++;
    endtask

    task automatic expect_single_one();
`ifdef ENC_TAIL_EN
        push_exp(2'b11, 1'b0, 1);
        push_exp(2'b10, 1'b0, 2);
        push_exp(2'b11, 1'b1, 3);
`else
        push_exp(2'b11, 1'b1, 1);
`endif
        done_exp++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_bp) sym_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_bit(input bit b, input bit l);
        bit acc;
        acc   = 1'b0;
        valid = 1'b1;
        data  = b;
        last  = l;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = ready;
            step();
        end
        valid = 1'b0;
        data  = 1'b0;
        last  = 1'b0;
        if (!acc) begin
            n_checks++;
            $display("FAIL accept_timeout bit=%0d last=%0d never accepted", b, l);
        end else if (rand_gap) begin
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    task automatic send_frame(input bit bits[$]);
        for (int i = 0; i < bits.size(); i++) send_bit(bits[i], i == bits.size() - 1);
        model_frame(bits);
    endtask

    task automatic drain_and_check(input string name);
        int  t;
        int  n;
        bit  keep_bp;
        keep_bp = rand_bp;
        for (t = 0; t < 1000 && got_q.size() < exp_q.size(); t++) step();
        rand_bp   = 0;
        sym_ready = 1'b1;
        repeat (3) step();
        rand_bp = keep_bp;
        n_checks++;
        if (got_q.size() != exp_q.size())
            $display("FAIL %s_count got %0d symbols expected %0d", name, got_q.size(), exp_q.size());
        else n_pass++;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (got_q[i].sym !== exp_q[i].sym)
                $display("FAIL %s_sym[%0d] got %b expected %b", name, i, got_q[i].sym, exp_q[i].sym);
            else n_pass++;
            n_checks++;
            if (got_q[i].last !== exp_q[i].last)
                $display("FAIL %s_last[%0d] got %b expected %b", name, i, got_q[i].last, exp_q[i].last);
            else n_pass++;
            n_checks++;
            if (got_q[i].cnt != exp_q[i].cnt)
                $display("FAIL %s_cnt[%0d] got %0d expected %0d", name, i, got_q[i].cnt, exp_q[i].cnt);
            else n_pass++;
        end
        n_checks++;
        if (done_seen != done_exp)
            $display("FAIL %s_frame_done got %0d pulses expected %0d", name, done_seen, done_exp);
        else n_pass++;
        n_checks++;
        if (sym_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s_idle got valid=%b busy=%b expected 0 0", name, sym_valid, busy);
        else n_pass++;
        got_q.delete();
        exp_q.delete();
        done_seen = 0;
        done_exp  = 0;
    endtask

    task automatic check_reset_outputs(input string name);
        n_checks++;
        if (sym !== 2'b00 || sym_valid !== 1'b0 || sym_last !== 1'b0 || sym_cnt !== '0 ||
            frame_done !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s got sym=%b valid=%b last=%b cnt=%0d done=%b busy=%b expected all zero",
                     name, sym, sym_valid, sym_last, sym_cnt, frame_done, busy);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        send_bit(1, 0);
        send_bit(0, 0);
        send_bit(1, 0);
        send_bit(1, 1);
        expect_1011();
        drain_and_check("basic");
    endtask

    task automatic test_single_bit();
        bit f[$];
        send_bit(1, 1);
`ifdef ENC_TAIL_EN
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (ready !== 1'b0) $display("FAIL single_tail_ready[%0d] got %b expected 0", i, ready);
            else n_pass++;
            step();
        end
`else
        n_checks++;
        if (ready !== 1'b1) $display("FAIL single_ready got %b expected 1", ready);
        else n_pass++;
`endif
        f.push_back(1'b1);
        model_frame(f);
        drain_and_check("single");
    endtask

    task automatic test_backpressure();
        logic [1:0] held;
        send_bit(1, 0);
        send_bit(0, 0);
        sym_ready = 1'b0;
        valid     = 1'b1;
        data      = 1'b1;
        held      = sym;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (sym !== held || sym_valid !== 1'b1 || ready !== 1'b0)
                $display("FAIL stall[%0d] got sym=%b valid=%b ready=%b expected %b 1 0",
                         i, sym, sym_valid, ready, held);
            else n_pass++;
            step();
        end
        sym_ready = 1'b1;
        valid     = 1'b0;
        send_bit(1, 0);
        send_bit(1, 1);
        expect_1011();
        drain_and_check("backpressure");
    endtask

    task automatic test_back_to_back();
        send_bit(1, 0);
        send_bit(0, 0);
        send_bit(1, 0);
        send_bit(1, 1);
        send_bit(1, 1);
        expect_1011();
        expect_single_one();
        drain_and_check("back_to_back");
    endtask

    task automatic test_reset_mid_frame();
        send_bit(1, 0);
        send_bit(0, 0);
        rst_n = 1'b0;
        step();
        check_reset_outputs("mid_reset");
        rst_n = 1'b1;
        n_checks++;
        if (done_seen != 0) $display("FAIL mid_reset_done got %0d pulses expected 0", done_seen);
        else n_pass++;
        got_q.delete();
        exp_q.delete();
        done_seen = 0;
        done_exp  = 0;
        step();
        send_bit(1, 0);
        send_bit(0, 0);
        send_bit(1, 0);
        send_bit(1, 1);
        expect_1011();
        drain_and_check("after_reset");
    endtask

    task automatic test_random();
        bit bits[$];
        int len;
        rand_bp  = 1;
        rand_gap = 1;
        for (int f = 0; f < 10; f++) begin
            len = (f == 0) ? 20 : $urandom_range(1, 22);
            bits.delete();
            repeat (len) bits.push_back(1'($urandom_range(0, 1)));
            send_frame(bits);
        end
        drain_and_check("random");
        rand_bp   = 0;
        rand_gap  = 0;
        sym_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single_bit();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/conv_encoder.md
Name: conv_encoder

Overview:
Rate-1/2, K=3 convolutional encoder with generator polynomials (111, 101). It is the transmit-side counterpart of the Viterbi decoder, and its shift-left state convention matches the decoder trellis.
- Accepts a bit stream through a valid/ready handshake.
- Emits one registered 2-bit symbol per input bit.
- Appends zero tail bits at frame end so the decoder trellis terminates in state 0.

Parameters:
CNT_WIDTH, 16, width of the per-frame symbol counter (saturating).

Ports:
clk_i  input  1  clock
rst_ni  input  1  synchronous active-low reset
data_i  input  1  information bit
valid_i  input  1  data_i valid
last_i  input  1  data_i is the final information bit of the frame (qualified by valid_i)
ready_o  output  1  encoder accepts data_i this cycle
sym_o  output  2  encoded symbol {X,Y}; sym_o[1]=X, sym_o[0]=Y
sym_valid_o  output  1  sym_o valid
sym_last_o  output  1  sym_o is the final symbol of the frame
sym_ready_i  input  1  downstream accepts sym_o
sym_cnt_o  output  CNT_WIDTH  symbols loaded into the output register in the current frame
frame_done_o  output  1  one-cycle pulse when the sym_last_o symbol handshakes out
busy_o  output  1  FSM not in IDLE

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is synchronous, active-low, and overrides everything.
  - Reset values: shift state s[1:0]=00, FSM=IDLE, sym_o=00, sym_valid_o=0, sym_last_o=0, sym_cnt_o=0, frame_done_o=0.
- Encoding:
  - s[1] is the oldest bit. For input bit b: X=b^s[0]^s[1], Y=b^s[1], next s={s[0],b}.
  - Equivalently, the encoding register is {s[1:0],b} with polynomials 111 and 101.
- Output slot: single-entry register.
  - slot_free = !sym_valid_o || sym_ready_i.
  - The symbol is loaded on the clock edge following acceptance, so latency is 1 cycle.
  - sym_o and sym_last_o are held stable while sym_valid_o=1 and sym_ready_i=0.
- Input handshake:
  - ready_o = slot_free && (FSM in IDLE or ENC). Combinational, no dependence on valid_i.
  - A bit is accepted when valid_i && ready_o.
- FSM:
  - IDLE: on accept, clear sym_cnt_o to 0 then count this symbol (sym_cnt_o=1 after the edge). Go to TAIL1 if last_i, else ENC.
  - ENC: on accept with last_i go to TAIL1, else stay in ENC.
  - TAIL1: ready_o=0. When slot_free, encode b=0, load the symbol with sym_last_o=0, go to TAIL2.
  - TAIL2: ready_o=0. When slot_free, encode b=0, load the symbol with sym_last_o=1, go to IDLE. s returns to 00 by construction.
  - In IDLE and ENC, the loaded sym_last_o is always 0.
- sym_cnt_o:
  - Increments on every symbol load and saturates at all-ones.
  - Holds its value after the frame ends, until the next frame's first accept.
- frame_done_o: asserted for the single cycle in which sym_valid_o && sym_ready_i && sym_last_o.
- If the slot drains and nothing reloads it in the same cycle, sym_valid_o falls.
- A simultaneous drain and load in the same cycle sustains full throughput (1 symbol/cycle).
- Reset mid-frame discards the pending symbol and any remaining tail; no frame_done_o pulse.
- valid_i without last_i may continue indefinitely; sym_cnt_o saturates, no error.

Optional Feature:
ENC_TAIL_EN
- Defined: tail insertion exactly as above, 2 tail symbols per frame.
- Undefined:
  - TAIL1 and TAIL2 are not built.
  - An accepted bit with last_i loads its symbol with sym_last_o=1, forces s to 00 after encoding, and returns the FSM to IDLE.
  - Frames carry no tail, so the symbol count equals the bit count.

Test Plan:
- Tail enabled, bits 1,0,1,1 (last on 4th), sym_ready_i=1 → sym_o 11,10,00,01,01,11; sym_last_o=1 only on 6th; sym_cnt_o=6; one frame_done_o pulse; s=00.
- Single-bit frame: 1 with last_i → 11,10,11; ready_o=0 for the 2 tail cycles; busy_o falls after the final handshake.
- Backpressure: sym_ready_i=0 for 3 cycles mid-frame → sym_o and sym_valid_o held, ready_o=0, no bit lost; the sequence completes identical to the first scenario.
- Back-to-back frames (1011 then 1), valid_i held high → second frame begins in s=00 and outputs 11,10,11; sym_cnt_o restarts at 1.
- rst_ni=0 for one cycle after the 2nd input bit → all outputs at reset values; a new frame 1011 reproduces the first scenario's output exactly.
- Tail disabled, bits 1,0,1,1 → 11,10,00,01 with sym_last_o on 4th; sym_cnt_o=4; the next frame 1 yields 11.
